// File: rtl/riscv_de_hazard_ctrl.sv
// Hazard and sequencing controller for the D/E pipeline register: stalls, flushes,
// execute-stage forwarding selects and the mul/div start/done handshake with watchdog.
module riscv_de_hazard_ctrl #(
   parameter int MD_TIMEOUT = 70
) (
   input  logic       i_riscv_de_clk,
   input  logic       i_riscv_de_rst,
   input  logic [4:0] i_riscv_de_rs1addr_d,
   input  logic [4:0] i_riscv_de_rs2addr_d,
   input  logic [4:0] i_riscv_de_rs1addr_e,
   input  logic [4:0] i_riscv_de_rs2addr_e,
   input  logic [4:0] i_riscv_de_rdaddr_e,
   input  logic [1:0] i_riscv_de_resultsrc_e,
   input  logic       i_riscv_de_regwrite_e,
   input  logic [4:0] i_riscv_de_rdaddr_m,
   input  logic       i_riscv_de_regwrite_m,
   input  logic [4:0] i_riscv_de_rdaddr_w,
   input  logic       i_riscv_de_regwrite_w,
   input  logic       i_riscv_de_branchtaken_e,
   input  logic       i_riscv_de_mdreq_e,
   input  logic       i_riscv_de_mddone,
   output logic       o_riscv_de_stall_f,
   output logic       o_riscv_de_stall_d,
   output logic       o_riscv_de_stall_e,
   output logic       o_riscv_de_flush_d,
   output logic       o_riscv_de_flush_de,
   output logic [1:0] o_riscv_de_fwda_e,
   output logic [1:0] o_riscv_de_fwdb_e,
   output logic       o_riscv_de_mdstart,
   output logic       o_riscv_de_mdtimeout
);

   localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             timeout_q;
   logic             timeout_hit;
   logic             md_start;
   logic             md_stall;
   logic             lw_stall;
   logic             run;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   always_ff @(posedge i_riscv_de_clk or posedge i_riscv_de_rst) begin
      if (i_riscv_de_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_hit;
      end
   end

   // Done takes priority over the watchdog; either one releases the stall in the same cycle.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      md_start    = 1'b0;
      md_stall    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (i_riscv_de_mdreq_e) begin
               md_start  = 1'b1;
               md_stall  = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = '0;
            end
         end
         BUSY: begin
            cnt_nxt = cnt + CNT_ONE;
            if (i_riscv_de_mddone) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end else begin
               md_stall = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lw_stall = (i_riscv_de_resultsrc_e == 2'b01) && i_riscv_de_regwrite_e &&
                 (i_riscv_de_rdaddr_e != 5'd0) &&
                 ((i_riscv_de_rdaddr_e == i_riscv_de_rs1addr_d) ||
                  (i_riscv_de_rdaddr_e == i_riscv_de_rs2addr_d));
   end

   // M stage is younger than W, so its result wins; x0 is never forwarded.
   always_comb begin
      fwd_a = 2'b00;
      if (i_riscv_de_regwrite_m && (i_riscv_de_rdaddr_m != 5'd0) &&
          (i_riscv_de_rdaddr_m == i_riscv_de_rs1addr_e))
         fwd_a = 2'b10;
      else if (i_riscv_de_regwrite_w && (i_riscv_de_rdaddr_w != 5'd0) &&
               (i_riscv_de_rdaddr_w == i_riscv_de_rs1addr_e))
         fwd_a = 2'b01;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (i_riscv_de_regwrite_m && (i_riscv_de_rdaddr_m != 5'd0) &&
          (i_riscv_de_rdaddr_m == i_riscv_de_rs2addr_e))
         fwd_b = 2'b10;
      else if (i_riscv_de_regwrite_w && (i_riscv_de_rdaddr_w != 5'd0) &&
               (i_riscv_de_rdaddr_w == i_riscv_de_rs2addr_e))
         fwd_b = 2'b01;
   end

   // Every output is held low while reset is asserted, including the combinational ones.
   assign run = ~i_riscv_de_rst;

   assign o_riscv_de_stall_f   = run & (md_stall | (lw_stall & ~i_riscv_de_branchtaken_e));
   assign o_riscv_de_stall_d   = run & (md_stall | (lw_stall & ~i_riscv_de_branchtaken_e));
   assign o_riscv_de_stall_e   = run & md_stall;
   assign o_riscv_de_flush_d   = run & i_riscv_de_branchtaken_e & ~md_stall;
   assign o_riscv_de_flush_de  = run & (lw_stall | i_riscv_de_branchtaken_e) & ~md_stall;
   assign o_riscv_de_fwda_e    = fwd_a & {2{run}};
   assign o_riscv_de_fwdb_e    = fwd_b & {2{run}};
   assign o_riscv_de_mdstart   = run & md_start;
   assign o_riscv_de_mdtimeout = run & timeout_q;

endmodule

// File: tb/tb_riscv_de_hazard_ctrl.sv
// Self-checking bench for riscv_de_hazard_ctrl: directed vector table, randomized
// hazard/forwarding checks against a rule-level model, and mul/div handshake sequences.
module tb_riscv_de_hazard_ctrl;

   localparam int T = 8;

   typedef struct {
      logic [4:0] rs1d;
      logic [4:0] rs2d;
      logic [4:0] rs1e;
      logic [4:0] rs2e;
      logic [4:0] rde;
      logic [1:0] rsrc;
      logic       regwe;
      logic [4:0] rdm;
      logic       regwm;
      logic [4:0] rdw;
      logic       regww;
      logic       br;
      logic       e_sfd;
      logic       e_se;
      logic       e_fd;
      logic       e_fde;
      logic [1:0] e_fa;
      logic [1:0] e_fb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
   logic [1:0] resultsrc_e = '0;
   logic       regwrite_e = 1'b0, regwrite_m = 1'b0, regwrite_w = 1'b0;
   logic       branchtaken_e = 1'b0, mdreq_e = 1'b0, mddone = 1'b0;
   logic       stall_f, stall_d, stall_e, flush_d, flush_de, mdstart, mdtimeout;
   logic [1:0] fwda_e, fwdb_e;

   int tests_run = 0;
   int tests_failed = 0;
   vec_t vecs[14];

   riscv_de_hazard_ctrl #(.MD_TIMEOUT(T)) dut (
      .i_riscv_de_clk          (clk),
      .i_riscv_de_rst          (rst),
      .i_riscv_de_rs1addr_d    (rs1_d),
      .i_riscv_de_rs2addr_d    (rs2_d),
      .i_riscv_de_rs1addr_e    (rs1_e),
      .i_riscv_de_rs2addr_e    (rs2_e),
      .i_riscv_de_rdaddr_e     (rd_e),
      .i_riscv_de_resultsrc_e  (resultsrc_e),
      .i_riscv_de_regwrite_e   (regwrite_e),
      .i_riscv_de_rdaddr_m     (rd_m),
      .i_riscv_de_regwrite_m   (regwrite_m),
      .i_riscv_de_rdaddr_w     (rd_w),
      .i_riscv_de_regwrite_w   (regwrite_w),
      .i_riscv_de_branchtaken_e(branchtaken_e),
      .i_riscv_de_mdreq_e      (mdreq_e),
      .i_riscv_de_mddone       (mddone),
      .o_riscv_de_stall_f      (stall_f),
      .o_riscv_de_stall_d      (stall_d),
      .o_riscv_de_stall_e      (stall_e),
      .o_riscv_de_flush_d      (flush_d),
      .o_riscv_de_flush_de     (flush_de),
      .o_riscv_de_fwda_e       (fwda_e),
      .o_riscv_de_fwdb_e       (fwdb_e),
      .o_riscv_de_mdstart      (mdstart),
      .o_riscv_de_mdtimeout    (mdtimeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s #%0d: got %0h, expected %0h", name, idx, actual, expected);
      end
   endtask

   // Hazard rules evaluated with no mul/div op in flight.
   function automatic vec_t refModel(input vec_t v);
      vec_t r = v;
      bit load_hit;
      load_hit = (v.rsrc == 2'b01) && v.regwe && (v.rde != 0) &&
                 ((v.rde == v.rs1d) || (v.rde == v.rs2d));
      r.e_sfd = load_hit && !v.br;
      r.e_se  = 1'b0;
      r.e_fd  = v.br;
      r.e_fde = load_hit || v.br;
      r.e_fa  = (v.regwm && v.rdm != 0 && v.rdm == v.rs1e) ? 2'b10 :
                (v.regww && v.rdw != 0 && v.rdw == v.rs1e) ? 2'b01 : 2'b00;
      r.e_fb  = (v.regwm && v.rdm != 0 && v.rdm == v.rs2e) ? 2'b10 :
                (v.regww && v.rdw != 0 && v.rdw == v.rs2e) ? 2'b01 : 2'b00;
      return r;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      rs1_d = v.rs1d; rs2_d = v.rs2d; rs1_e = v.rs1e; rs2_e = v.rs2e; rd_e = v.rde;
      resultsrc_e = v.rsrc; regwrite_e = v.regwe; rd_m = v.rdm; regwrite_m = v.regwm;
      rd_w = v.rdw; regwrite_w = v.regww; branchtaken_e = v.br;
      mdreq_e = 1'b0; mddone = 1'b0;
   endtask

   task automatic checkVec(input string name, input int idx, input vec_t v);
      @(negedge clk);
      checkOutput({name, "_stall_f"}, idx, 32'(stall_f), 32'(v.e_sfd));
      checkOutput({name, "_stall_d"}, idx, 32'(stall_d), 32'(v.e_sfd));
      checkOutput({name, "_stall_e"}, idx, 32'(stall_e), 32'(v.e_se));
      checkOutput({name, "_flush_d"}, idx, 32'(flush_d), 32'(v.e_fd));
      checkOutput({name, "_flush_de"}, idx, 32'(flush_de), 32'(v.e_fde));
      checkOutput({name, "_fwda"}, idx, 32'(fwda_e), 32'(v.e_fa));
      checkOutput({name, "_fwdb"}, idx, 32'(fwdb_e), 32'(v.e_fb));
      checkOutput({name, "_mdstart"}, idx, 32'(mdstart), 32'd0);
   endtask

   task automatic clearInputs();
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
      resultsrc_e = '0; regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
      branchtaken_e = 1'b0; mdreq_e = 1'b0; mddone = 1'b0;
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_outputs"}, 0,
                  {23'd0, stall_f, stall_d, stall_e, flush_d, flush_de, mdstart, mdtimeout,
                   |fwda_e, |fwdb_e}, 32'd0);
   endtask

   // Drives a mul/div op whose done pulse arrives `latency` cycles after start (0 = never).
   task automatic runMdOp(input int latency, input int idx);
      int stall_cnt = 0, start_cnt = 0, flush_cnt = 0, mism = 0, k = 0, exp_stall;
      bit released = 0, first_start = 0, timed_out;
      timed_out = (latency == 0) || (latency > T);
      exp_stall = timed_out ? T : latency;
      while (!released && k <= T + 2) begin
         @(posedge clk);
         #1;
         mdreq_e = 1'b1;
         mddone  = (latency != 0) && (k == latency);
         @(negedge clk);
         if (k == 0) first_start = mdstart;
         if (stall_e) stall_cnt++;
         else released = 1;
         start_cnt += int'(mdstart);
         flush_cnt += int'(flush_de | flush_d);
         mism += int'((stall_f != stall_e) || (stall_d != stall_e));
         k++;
      end
      checkOutput("md_released", idx, 32'(released), 32'd1);
      checkOutput("md_stall_cycles", idx, 32'(stall_cnt), 32'(exp_stall));
      checkOutput("md_start_first", idx, 32'(first_start), 32'd1);
      checkOutput("md_start_count", idx, 32'(start_cnt), 32'd1);
      checkOutput("md_flush_count", idx, 32'(flush_cnt), 32'd0);
      checkOutput("md_stall_fde_match", idx, 32'(mism), 32'd0);
      @(posedge clk);
      #1;
      mdreq_e = 1'b0; mddone = 1'b0;
      @(negedge clk);
      checkOutput("md_timeout_pulse", idx, 32'(mdtimeout), 32'(timed_out));
      checkOutput("md_idle_stall", idx, 32'(stall_e), 32'd0);
      checkOutput("md_idle_start", idx, 32'(mdstart), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("md_timeout_clear", idx, 32'(mdtimeout), 32'd0);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{5'd1, 5'd5, 5'd0, 5'd0, 5'd5, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
      vecs[1]  = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[2]  = '{5'd5, 5'd2, 5'd0, 5'd0, 5'd5, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1,
                   1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
      vecs[3]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[4]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
      vecs[8]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[9]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[10] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1,
                   1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
      vecs[12] = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 2'b00, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
      vecs[13] = '{5'd9, 5'd1, 5'd2, 5'd2, 5'd9, 2'b01, 1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10};

      // Reset with inputs that would otherwise drive every output high.
      rs1_e = 5'd7; rs2_e = 5'd7; rd_m = 5'd7; regwrite_m = 1'b1;
      rd_e = 5'd5; rs1_d = 5'd5; resultsrc_e = 2'b01; regwrite_e = 1'b1;
      branchtaken_e = 1'b1; mdreq_e = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("reset_initial");
      clearInputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("after_reset");

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         checkVec("vec", i, vecs[i]);
      end

      for (int i = 0; i < 250; i++) begin
         v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
         v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
         v.rde  = 5'($urandom_range(0, 3)); v.rsrc = 2'($urandom_range(0, 3));
         v.regwe = 1'($urandom); v.rdm = 5'($urandom_range(0, 3)); v.regwm = 1'($urandom);
         v.rdw = 5'($urandom_range(0, 3)); v.regww = 1'($urandom);
         v.br = ($urandom_range(0, 3) == 0);
         v = refModel(v);
         applyStimulus(v);
         checkVec("rand", i, v);
      end
      clearInputs();

      runMdOp(4, 0);
      runMdOp(0, 1);
      runMdOp(1, 2);
      runMdOp(T, 3);
      runMdOp(T + 1, 4);
      for (int i = 0; i < 6; i++) runMdOp(int'($urandom_range(1, 12)), 10 + i);

      // A stray done pulse while idle must not disturb anything.
      @(posedge clk);
      #1;
      mddone = 1'b1;
      @(negedge clk);
      checkOutput("idle_done_stall", 0, 32'(stall_e), 32'd0);
      @(posedge clk);
      #1;
      mddone = 1'b0;
      @(negedge clk);
      checkOutput("idle_done_timeout", 0, 32'(mdtimeout), 32'd0);
      checkOutput("idle_done_start", 0, 32'(mdstart), 32'd0);

      // Reset in the middle of a busy op, at count 5.
      @(posedge clk);
      #1;
      mdreq_e = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      rs1_e = 5'd7; rd_m = 5'd7; regwrite_m = 1'b1; branchtaken_e = 1'b1;
      rst = 1'b1;
      #1;
      checkAllZero("reset_midbusy");
      @(posedge clk);
      #1;
      clearInputs();
      mdreq_e = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_start", 0, 32'(mdstart), 32'd1);
      checkOutput("post_reset_stall", 0, 32'(stall_e), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("post_reset_busy_start", 0, 32'(mdstart), 32'd0);
      checkOutput("post_reset_busy_stall", 0, 32'(stall_e), 32'd1);
      @(posedge clk);
      #1;
      mddone = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_done_stall", 0, 32'(stall_f), 32'd0);
      @(posedge clk);
      #1;
      clearInputs();
      @(negedge clk);
      checkOutput("post_reset_idle_stall", 0, 32'(stall_e), 32'd0);
      checkOutput("post_reset_idle_timeout", 0, 32'(mdtimeout), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
